svm_stage_engine: RTL and testbench

SVM_STAGE_ENGINE -- requirements
Module: svm_stage_engine

---
 rtl/svm_stage_engine.sv | 206 ++++++++++++++++++++
 tb/tb_svm_stage_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_stage_engine.sv
// svm_stage_engine: one SVM cascade stage; buffers a test vector, MACs it against
// NUM_GROUPS groups of NUM_LANES support vectors, then scales by alpha*y and adds bias.
// Latency: NUM_GROUPS*(NUM_OF_PIXELS+2) cycles from last pixel accepted to res_valid.
// Backpressure: pix_ready only in IDLE/LOAD; result held in DONE until res_ready.
// Optional feature macro: SVM_STAGE_MARGIN_EN (confidence = |decision| >= margin).
module svm_stage_engine #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 87,
  parameter int NUM_LANES     = 8,
  parameter int COEF_W        = 16,
  localparam int NUM_GROUPS   = (NUM_OF_SV + NUM_LANES - 1) / NUM_LANES,
  localparam int DOT_W        = 2 * XLEN_PIXEL + $clog2(NUM_OF_PIXELS),
  localparam int ACC_W        = DOT_W + COEF_W + $clog2(NUM_OF_SV) + 1,
  localparam int SV_ADDR_W    = ($clog2(NUM_GROUPS * NUM_OF_PIXELS) > 0) ? $clog2(NUM_GROUPS * NUM_OF_PIXELS) : 1,
  localparam int COEF_ADDR_W  = ($clog2(NUM_GROUPS) > 0) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic [XLEN_PIXEL-1:0]           pix_data,
  output logic                            sv_rd_en,
  output logic [SV_ADDR_W-1:0]            sv_rd_addr,
  input  logic [NUM_LANES*XLEN_PIXEL-1:0] sv_rd_data,
  output logic [COEF_ADDR_W-1:0]          coef_rd_addr,
  input  logic [NUM_LANES*COEF_W-1:0]     coef_rd_data,
  input  logic [ACC_W-1:0]                bias,
  input  logic [ACC_W-1:0]                margin,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            y_class,
  output logic                            confident,
  output logic [ACC_W-1:0]                decision_funct_out
);

  localparam int CNT_W = $clog2(NUM_OF_PIXELS + 1);
  localparam int IDX_W = ($clog2(NUM_OF_PIXELS) > 0) ? $clog2(NUM_OF_PIXELS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, SCALE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COEF_ADDR_W-1:0]  grp_q, grp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DOT_W-1:0]        dot_q [NUM_LANES];
  logic [DOT_W-1:0]        dot_d [NUM_LANES];
  logic [XLEN_PIXEL-1:0]   pix_rd_q, pix_rd_d;
  logic                    rd_vld_q, rd_vld_d;

  logic                    pix_wr;
  logic                    rd_issue;
  logic [IDX_W-1:0]        pidx;
  logic [XLEN_PIXEL-1:0]   pix_buf [NUM_OF_PIXELS];
  logic [2*XLEN_PIXEL-1:0] lane_prod [NUM_LANES];
  logic signed [ACC_W-1:0] scale_sum;

  assign pidx     = cnt_q[IDX_W-1:0];
  assign pix_wr   = pix_valid && pix_ready;
  // One SV read per cycle while the pixel counter has not reached the drain slot.
  assign rd_issue = (state_q == MAC) && (int'(cnt_q) < NUM_OF_PIXELS);

  // Test-vector buffer; deliberately not reset so an abort costs nothing.
  always_ff @(posedge clk) begin
    if (pix_wr) pix_buf[pidx] <= pix_data;
  end

  // Per-lane unsigned products of the registered pixel and returning SV element.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_prod[k] = pix_rd_q * sv_rd_data[k*XLEN_PIXEL +: XLEN_PIXEL];
    end
  end

  // Group scale term; padding lanes past the last SV are masked to zero.
  always_comb begin
    scale_sum = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (int'(grp_q) * NUM_LANES + k < NUM_OF_SV) begin
        scale_sum = scale_sum +
          ($signed({{(ACC_W-DOT_W){1'b0}}, dot_q[k]}) *
           $signed({{(ACC_W-COEF_W){coef_rd_data[k*COEF_W+COEF_W-1]}}, coef_rd_data[k*COEF_W +: COEF_W]}));
      end
    end
  end

  // Next-state logic: load, per-group MAC + drain, scale, hold result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grp_d    = grp_q;
    acc_d    = acc_q;
    pix_rd_d = rd_issue ? pix_buf[pidx] : pix_rd_q;
    rd_vld_d = rd_issue;
    for (int k = 0; k < NUM_LANES; k++) begin
      dot_d[k] = rd_vld_q ? dot_q[k] + DOT_W'(lane_prod[k]) : dot_q[k];
    end
    case (state_q)
      IDLE: begin
        if (pix_valid) begin
          acc_d = $signed(bias);
          if (NUM_OF_PIXELS == 1) begin
            state_d = MAC;
            cnt_d   = '0;
            for (int k = 0; k < NUM_LANES; k++) dot_d[k] = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (pix_valid) begin
          if (int'(cnt_q) == NUM_OF_PIXELS - 1) begin
            state_d = MAC;
            cnt_d   = '0;
            for (int k = 0; k < NUM_LANES; k++) dot_d[k] = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MAC: begin
        if (rd_issue) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = SCALE;
          cnt_d   = '0;
        end
      end
      SCALE: begin
        acc_d = acc_q + scale_sum;
        if (int'(grp_q) == NUM_GROUPS - 1) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
          grp_d   = grp_q + COEF_ADDR_W'(1);
          for (int k = 0; k < NUM_LANES; k++) dot_d[k] = '0;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          grp_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grp_q    <= '0;
      acc_q    <= '0;
      pix_rd_q <= '0;
      rd_vld_q <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) dot_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grp_q    <= grp_d;
      acc_q    <= acc_d;
      pix_rd_q <= pix_rd_d;
      rd_vld_q <= rd_vld_d;
      for (int k = 0; k < NUM_LANES; k++) dot_q[k] <= dot_d[k];
    end
  end

  assign pix_ready          = (state_q == IDLE) || (state_q == LOAD);
  assign sv_rd_en           = rd_issue;
  assign sv_rd_addr         = SV_ADDR_W'(int'(grp_q) * NUM_OF_PIXELS + int'(cnt_q));
  assign coef_rd_addr       = grp_q;
  assign res_valid          = (state_q == DONE);
  assign decision_funct_out = res_valid ? acc_q : '0;
  assign y_class            = res_valid && !acc_q[ACC_W-1];

`ifdef SVM_STAGE_MARGIN_EN
  logic [ACC_W-1:0] margin_q, margin_d;
  logic [ACC_W-1:0] acc_abs;

  // Margin captured alongside bias on the first accepted pixel.
  always_comb begin
    margin_d = margin_q;
    if (state_q == IDLE && pix_valid) margin_d = margin;
    acc_abs = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
  end

  // Margin register.
  always_ff @(posedge clk) begin
    if (rst) margin_q <= '0;
    else     margin_q <= margin_d;
  end

  assign confident = res_valid && (acc_abs >= margin_q);
`else
  logic margin_unused;
  assign margin_unused = ^margin;
  assign confident     = res_valid;
`endif

endmodule

// File: tb/tb_svm_stage_engine.sv
// Directed bench for svm_stage_engine with a small configuration.
// Expected decisions come from constants and a behavioural model into a scoreboard queue.
module tb_svm_stage_engine;

  localparam int X     = 8;
  localparam int P     = 4;
  localparam int SV    = 3;
  localparam int L     = 2;
  localparam int C     = 16;
  localparam int G     = (SV + L - 1) / L;
  localparam int DOT_W = 2 * X + $clog2(P);
  localparam int ACC_W = DOT_W + C + $clog2(SV) + 1;
  localparam int AW    = ($clog2(G * P) > 0) ? $clog2(G * P) : 1;
  localparam int CAW   = ($clog2(G) > 0) ? $clog2(G) : 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_valid;
  logic             pix_ready;
  logic [X-1:0]     pix_data;
  logic             sv_rd_en;
  logic [AW-1:0]    sv_rd_addr;
  logic [L*X-1:0]   sv_rd_data;
  logic [CAW-1:0]   coef_rd_addr;
  logic [L*C-1:0]   coef_rd_data;
  logic [ACC_W-1:0] bias;
  logic [ACC_W-1:0] margin;
  logic             res_valid;
  logic             res_ready;
  logic             y_class;
  logic             confident;
  logic [ACC_W-1:0] decision_funct_out;

  svm_stage_engine #(
    .XLEN_PIXEL(X), .NUM_OF_PIXELS(P), .NUM_OF_SV(SV), .NUM_LANES(L), .COEF_W(C)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .sv_rd_en(sv_rd_en), .sv_rd_addr(sv_rd_addr), .sv_rd_data(sv_rd_data),
    .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .bias(bias), .margin(margin),
    .res_valid(res_valid), .res_ready(res_ready),
    .y_class(y_class), .confident(confident),
    .decision_funct_out(decision_funct_out)
  );

  always #5 clk = ~clk;

  logic [L*X-1:0] sv_mem   [G*P];
  logic [L*C-1:0] coef_mem [G];
  logic [X-1:0]   pix_arr  [P];
  int             rd_total = 0;
  int             rd_snap  = 0;
  int             checks   = 0;
  int             errors   = 0;
  logic [ACC_W-1:0] exp_q  [$];
  bit               conf_q [$];

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    if (sv_rd_en) begin
      sv_rd_data <= sv_mem[sv_rd_addr];
      rd_total   = rd_total + 1;
    end
    coef_rd_data <= coef_mem[coef_rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic longint model(input longint b);
    longint acc;
    longint dot;
    logic signed [C-1:0] cs;
    acc = b;
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < L; k++) begin
        if (g * L + k < SV) begin
          dot = 0;
          for (int p = 0; p < P; p++) begin
            dot += longint'(pix_arr[p]) * longint'(sv_mem[g*P+p][k*X +: X]);
          end
          cs = coef_mem[g][k*C +: C];
          acc += dot * longint'(cs);
        end
      end
    end
    return acc;
  endfunction

  function automatic bit exp_conf(input longint v, input longint m);
    longint a;
    bit     c;
    a = (v < 0) ? -v : v;
    c = (a >= m);
`ifndef SVM_STAGE_MARGIN_EN
    c = 1'b1;
`endif
    return c;
  endfunction

  task automatic push_exp(input longint v);
    exp_q.push_back(ACC_W'(v));
    conf_q.push_back(exp_conf(v, longint'(margin)));
  endtask

  task automatic set_sv_all(input logic [X-1:0] v);
    for (int a = 0; a < G * P; a++) sv_mem[a] = {L{v}};
  endtask

  task automatic set_coefs(input logic [C-1:0] c0, input logic [C-1:0] c1,
                           input logic [C-1:0] c2, input logic [C-1:0] pad);
    coef_mem[0] = {c1, c0};
    coef_mem[1] = {pad, c2};
  endtask

  task automatic set_pix(input int a, input int b, input int c, input int d);
    pix_arr[0] = X'(a); pix_arr[1] = X'(b); pix_arr[2] = X'(c); pix_arr[3] = X'(d);
  endtask

  task automatic send(input bit toggle);
    rd_snap = rd_total;
    for (int p = 0; p < P; p++) begin
      if (toggle && p > 0) begin
        pix_valid = 1'b0;
        tick();
      end
      pix_valid = 1'b1;
      pix_data  = pix_arr[p];
      tick();
    end
    pix_valid = 1'b0;
  endtask

  // Waits for the result, optionally holds it with res_ready low, then pops and compares.
  task automatic wait_result(input string tag, input int hold);
    int n;
    logic [ACC_W-1:0] e;
    bit ec;
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(G * (P + 2)));
    check({tag, "_rd_count"}, 64'(rd_total - rd_snap), 64'(G * P));
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    ec = (conf_q.size() > 0) ? conf_q.pop_front() : 1'b0;
    for (int i = 0; i < hold; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'hA5;
      check({tag, "_hold_dfo"}, 64'(decision_funct_out), 64'(e));
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_pix_ready"}, 64'(pix_ready), 64'd0);
      check({tag, "_hold_rd_en"}, 64'(sv_rd_en), 64'd0);
      tick();
    end
    pix_valid = 1'b0;
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_dfo"}, 64'(decision_funct_out), 64'(e));
    check({tag, "_y_class"}, 64'(y_class), 64'(!e[ACC_W-1]));
    check({tag, "_confident"}, 64'(confident), 64'(ec));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_post_pix_ready"}, 64'(pix_ready), 64'd1);
  endtask

  initial begin
    int stray;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
    bias = '0; margin = '0;
    set_sv_all(8'd1);
    set_coefs(16'd1, 16'hFFFF, 16'd2, 16'd0);
    set_pix(1, 2, 3, 4);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_pix_ready", 64'(pix_ready), 64'd1);
    check("rst_rd_en", 64'(sv_rd_en), 64'd0);
    check("rst_y_class", 64'(y_class), 64'd0);
    check("rst_confident", 64'(confident), 64'd0);
    check("rst_dfo", 64'(decision_funct_out), 64'd0);

    // Coefs {1,-1,2}, bias 0: 10 - 10 + 20 = 20
    push_exp(20);
    send(1'b0);
    wait_result("t1", 0);

    // Coefs {-1,-1,-1}, bias 5: 5 - 30 = -25
    set_coefs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0);
    bias = ACC_W'(5);
    push_exp(-25);
    send(1'b0);
    wait_result("t2", 0);

    // Padding lane coefficient must be ignored
    set_coefs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF);
    push_exp(-25);
    send(1'b0);
    wait_result("t2_pad", 0);

    // Gapped input and held result
    set_coefs(16'd1, 16'hFFFF, 16'd2, 16'h1234);
    bias = '0;
    push_exp(20);
    send(1'b1);
    wait_result("t3", 10);

    // Reset mid-MAC aborts the vector
    send(1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_res_valid", 64'(res_valid), 64'd0);
    check("abort_pix_ready", 64'(pix_ready), 64'd1);
    check("abort_rd_en", 64'(sv_rd_en), 64'd0);
    check("abort_dfo", 64'(decision_funct_out), 64'd0);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid !== 1'b0) stray++;
      tick();
    end
    check("abort_no_result", 64'(stray), 64'd0);

    // Fresh vector after abort: dots 26, 26 - 26 + 52 - 3 = 49
    set_pix(5, 6, 7, 8);
    bias = ACC_W'(-3);
    push_exp(49);
    send(1'b0);
    wait_result("t4", 0);

    // Margin boundary around |20|
    set_pix(1, 2, 3, 4);
    bias = '0;
    margin = ACC_W'(21);
    push_exp(20);
    send(1'b0);
    wait_result("t5_m21", 0);
    margin = ACC_W'(20);
    push_exp(20);
    send(1'b0);
    wait_result("t5_m20", 0);

    // Random vector against the behavioural model
    margin = '0;
    for (int p = 0; p < P; p++) pix_arr[p] = X'($urandom_range(0, 255));
    for (int a = 0; a < G * P; a++) sv_mem[a] = (L*X)'($urandom);
    set_coefs(C'($urandom_range(0, 65535)), C'($urandom_range(0, 65535)),
              C'($urandom_range(0, 65535)), C'($urandom_range(0, 65535)));
    bias = ACC_W'(longint'($urandom_range(0, 2000)) - 1000);
    push_exp(model(longint'($signed(bias))));
    send(1'b0);
    wait_result("t6_rand", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
